// File: rtl/z_event_monitor.sv
// z_event_monitor: turns the detector level flag z into event pulses and keeps
// running statistics: total events, current/longest high run, per-window event
// count, and a sticky alarm when a window reaches the event threshold.
module z_event_monitor #(
  parameter int CNT_W   = 8,
  parameter int RUN_W   = 8,
  parameter int WIN_LEN = 16,
  parameter int THRESH  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             det_in,
  input  logic             clr,
  output logic             evt_pulse,
  output logic [CNT_W-1:0] evt_count,
  output logic [RUN_W-1:0] run_len,
  output logic [RUN_W-1:0] max_run,
  output logic [CNT_W-1:0] win_count,
  output logic             win_valid,
  output logic             alarm
);

  localparam int TMR_W = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] THRESH_CT = CNT_W'(THRESH);

  logic             det_q;
  logic [TMR_W-1:0] win_tmr;
  logic [CNT_W-1:0] win_acc;

  logic             evt;
  logic [CNT_W-1:0] evt_count_nxt;
  logic [CNT_W-1:0] win_acc_nxt;
  logic [RUN_W-1:0] run_len_nxt;
  logic             win_close;

  // Saturating increment for event counters: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v,
                                                   input logic inc);
    if (inc && (v != {CNT_W{1'b1}}))
      return v + 1'b1;
    return v;
  endfunction

  // Saturating increment for run-length counters.
  function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] v);
    if (v != {RUN_W{1'b1}})
      return v + 1'b1;
    return v;
  endfunction

  // Next-state terms shared by the statistics registers.
  always_comb begin
    evt           = det_in & ~det_q;
    evt_count_nxt = sat_inc_cnt(evt_count, evt);
    win_acc_nxt   = sat_inc_cnt(win_acc, evt);
    run_len_nxt   = det_in ? sat_inc_run(run_len) : '0;
    win_close     = (win_tmr == TMR_LAST);
  end

  // Previous-sample register; keeps tracking det_in through clr so a level held
  // across clr release is not mistaken for a new rising edge.
  always_ff @(posedge clk) begin
    if (!rst)
      det_q <= 1'b0;
    else
      det_q <= det_in;
  end

  // Statistics, window timer and alarm; reset beats clr, clr beats a window close.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      evt_pulse <= 1'b0;
      evt_count <= '0;
      run_len   <= '0;
      max_run   <= '0;
      win_count <= '0;
      win_valid <= 1'b0;
      alarm     <= 1'b0;
      win_tmr   <= '0;
      win_acc   <= '0;
    end else begin
      evt_pulse <= evt;
      evt_count <= evt_count_nxt;
      run_len   <= run_len_nxt;
      if (run_len_nxt > max_run)
        max_run <= run_len_nxt;
      if (win_close) begin
        // An event on the closing edge is credited to the window being closed.
        win_tmr   <= '0;
        win_acc   <= '0;
        win_count <= win_acc_nxt;
        win_valid <= 1'b1;
        if (win_acc_nxt >= THRESH_CT)
          alarm <= 1'b1;
      end else begin
        win_tmr   <= win_tmr + 1'b1;
        win_acc   <= win_acc_nxt;
        win_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_z_event_monitor.sv
// Directed testbench for z_event_monitor: a default-width instance (a_*) and a
// 4-bit counter instance (b_*) share the same stimulus.
module tb_z_event_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, det_in, clr;

  logic       a_evt_pulse, a_win_valid, a_alarm;
  logic [7:0] a_evt_count, a_run_len, a_max_run, a_win_count;
  logic       b_evt_pulse, b_win_valid, b_alarm;
  logic [3:0] b_evt_count, b_run_len, b_max_run, b_win_count;

  int n_chk  = 0;
  int n_fail = 0;

  z_event_monitor #(.CNT_W(8), .RUN_W(8), .WIN_LEN(16), .THRESH(3)) dut_a (
    .clk(clk), .rst(rst), .det_in(det_in), .clr(clr),
    .evt_pulse(a_evt_pulse), .evt_count(a_evt_count), .run_len(a_run_len),
    .max_run(a_max_run), .win_count(a_win_count), .win_valid(a_win_valid),
    .alarm(a_alarm)
  );

  z_event_monitor #(.CNT_W(4), .RUN_W(4), .WIN_LEN(16), .THRESH(3)) dut_b (
    .clk(clk), .rst(rst), .det_in(det_in), .clr(clr),
    .evt_pulse(b_evt_pulse), .evt_count(b_evt_count), .run_len(b_run_len),
    .max_run(b_max_run), .win_count(b_win_count), .win_valid(b_win_valid),
    .alarm(b_alarm)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; clr = 1'b0; det_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_chk++;
      if ({a_evt_pulse, a_evt_count, a_run_len, a_max_run, a_win_count, a_win_valid, a_alarm} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc%0d: got pulse=%0b cnt=%0d run=%0d max=%0d win=%0d wv=%0b alarm=%0b, expected all 0",
                 i, a_evt_pulse, a_evt_count, a_run_len, a_max_run, a_win_count, a_win_valid, a_alarm);
      end
    end
    rst = 1'b1;
    step();
    n_chk++;
    if (a_evt_pulse !== 1'b1) begin n_fail++; $display("FAIL first_evt_pulse: got %0b expected 1", a_evt_pulse); end
    n_chk++;
    if (a_evt_count !== 8'd1) begin n_fail++; $display("FAIL first_evt_count: got %0d expected 1", a_evt_count); end
    n_chk++;
    if (a_run_len !== 8'd1) begin n_fail++; $display("FAIL first_run_len: got %0d expected 1", a_run_len); end
  endtask

  task automatic test_pattern();
    int pat[10]     = '{0, 1, 0, 1, 1, 0, 1, 1, 1, 0};
    int exp_evt[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 0, 0};
    int exp_run[10] = '{0, 1, 0, 1, 2, 0, 1, 2, 3, 0};
    det_in = 1'b0;
    do_clr();
    for (int i = 0; i < 10; i++) begin
      det_in = pat[i][0];
      step();
      n_chk++;
      if (a_evt_pulse !== exp_evt[i][0]) begin
        n_fail++; $display("FAIL pattern_pulse[%0d]: got %0b expected %0d", i, a_evt_pulse, exp_evt[i]);
      end
      n_chk++;
      if (a_run_len !== 8'(exp_run[i])) begin
        n_fail++; $display("FAIL pattern_run[%0d]: got %0d expected %0d", i, a_run_len, exp_run[i]);
      end
    end
    n_chk++;
    if (a_evt_count !== 8'd3) begin n_fail++; $display("FAIL pattern_evt_count: got %0d expected 3", a_evt_count); end
    n_chk++;
    if (a_max_run !== 8'd3) begin n_fail++; $display("FAIL pattern_max_run: got %0d expected 3", a_max_run); end
  endtask

  task automatic test_window();
    det_in = 1'b0;
    do_clr();
    for (int k = 1; k <= 32; k++) begin
      det_in = (k == 2 || k == 5 || k == 16);
      step();
      n_chk++;
      if (a_win_valid !== (k == 16 || k == 32)) begin
        n_fail++; $display("FAIL window_valid edge%0d: got %0b expected %0b", k, a_win_valid, (k == 16 || k == 32));
      end
      if (k == 15) begin
        n_chk++;
        if (a_alarm !== 1'b0) begin n_fail++; $display("FAIL window_alarm_early: got %0b expected 0", a_alarm); end
      end
      if (k == 16) begin
        n_chk++;
        if (a_win_count !== 8'd3) begin n_fail++; $display("FAIL window1_count: got %0d expected 3", a_win_count); end
        n_chk++;
        if (a_alarm !== 1'b1) begin n_fail++; $display("FAIL window1_alarm: got %0b expected 1", a_alarm); end
      end
      if (k == 32) begin
        n_chk++;
        if (a_win_count !== 8'd0) begin n_fail++; $display("FAIL window2_count: got %0d expected 0", a_win_count); end
        n_chk++;
        if (a_alarm !== 1'b1) begin n_fail++; $display("FAIL window2_alarm_sticky: got %0b expected 1", a_alarm); end
      end
    end
  endtask

  task automatic test_clear();
    det_in = 1'b1;
    step();
    step();
    clr = 1'b1;
    step();
    n_chk++;
    if ({a_evt_pulse, a_evt_count, a_run_len, a_max_run, a_win_count, a_win_valid, a_alarm} !== '0) begin
      n_fail++;
      $display("FAIL clear_outputs: got pulse=%0b cnt=%0d run=%0d max=%0d win=%0d wv=%0b alarm=%0b, expected all 0",
               a_evt_pulse, a_evt_count, a_run_len, a_max_run, a_win_count, a_win_valid, a_alarm);
    end
    clr = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      n_chk++;
      if (a_evt_pulse !== 1'b0) begin n_fail++; $display("FAIL clear_no_pulse edge%0d: got %0b expected 0", k, a_evt_pulse); end
      n_chk++;
      if (a_win_valid !== (k == 16)) begin
        n_fail++; $display("FAIL clear_win_restart edge%0d: got %0b expected %0b", k, a_win_valid, (k == 16));
      end
    end
    n_chk++;
    if (a_evt_count !== 8'd0) begin n_fail++; $display("FAIL clear_evt_count: got %0d expected 0", a_evt_count); end
    n_chk++;
    if (a_run_len !== 8'd16) begin n_fail++; $display("FAIL clear_run_len: got %0d expected 16", a_run_len); end
    n_chk++;
    if (a_alarm !== 1'b0) begin n_fail++; $display("FAIL clear_alarm: got %0b expected 0", a_alarm); end
  endtask

  task automatic test_saturation();
    det_in = 1'b0;
    do_clr();
    for (int i = 0; i < 20; i++) begin
      det_in = 1'b1; step();
      det_in = 1'b0; step();
    end
    n_chk++;
    if (b_evt_count !== 4'd15) begin n_fail++; $display("FAIL sat_evt_count_4b: got %0d expected 15", b_evt_count); end
    n_chk++;
    if (a_evt_count !== 8'd20) begin n_fail++; $display("FAIL sat_evt_count_8b: got %0d expected 20", a_evt_count); end
    do_clr();
    det_in = 1'b1;
    for (int i = 0; i < 20; i++) step();
    n_chk++;
    if (b_run_len !== 4'd15) begin n_fail++; $display("FAIL sat_run_len_4b: got %0d expected 15", b_run_len); end
    n_chk++;
    if (b_max_run !== 4'd15) begin n_fail++; $display("FAIL sat_max_run_4b: got %0d expected 15", b_max_run); end
    n_chk++;
    if (a_max_run !== 8'd20) begin n_fail++; $display("FAIL sat_max_run_8b: got %0d expected 20", a_max_run); end
    det_in = 1'b0;
    step();
    n_chk++;
    if (b_run_len !== 4'd0) begin n_fail++; $display("FAIL sat_run_drop: got %0d expected 0", b_run_len); end
    n_chk++;
    if (b_max_run !== 4'd15) begin n_fail++; $display("FAIL sat_max_hold: got %0d expected 15", b_max_run); end
  endtask

  task automatic test_mid_reset();
    det_in = 1'b0;
    do_clr();
    det_in = 1'b1; step();
    det_in = 1'b0; step();
    det_in = 1'b1; step();
    det_in = 1'b0; step();
    rst = 1'b0;
    step();
    n_chk++;
    if ({a_evt_count, a_win_count, a_win_valid, a_alarm} !== '0) begin
      n_fail++; $display("FAIL midrst_outputs: got cnt=%0d win=%0d wv=%0b alarm=%0b expected 0",
                         a_evt_count, a_win_count, a_win_valid, a_alarm);
    end
    rst = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      n_chk++;
      if (a_win_valid !== (k == 16)) begin
        n_fail++; $display("FAIL midrst_win_valid edge%0d: got %0b expected %0b", k, a_win_valid, (k == 16));
      end
    end
    n_chk++;
    if (a_win_count !== 8'd0) begin n_fail++; $display("FAIL midrst_win_count: got %0d expected 0", a_win_count); end
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; det_in = 1'b0;
    test_reset();
    test_pattern();
    test_window();
    test_clear();
    test_saturation();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
